// File: rtl/carbon_init_seq_pkg.sv
// carbon_init_seq shared types and constants.
// State encoding and index width used by the init sequencer.
package carbon_init_seq_pkg;

  localparam int CARBON_INIT_SEQ_IDX_W = 6;
  localparam int TMR_W = 16;
  localparam int RTY_W = 4;

  localparam logic [3:0] CMD_WSTRB = 4'hF;
  localparam logic [1:0] CMD_PRIV  = 2'd1;

  typedef enum logic [3:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_VERIFY_ISSUE,
    S_VERIFY_WAIT,
    S_NEXT,
    S_RELEASE,
    S_DONE,
    S_ERROR
  } state_t;

  function automatic logic is_issue(state_t s);
    return (s == S_ISSUE) || (s == S_VERIFY_ISSUE);
  endfunction

  function automatic logic is_wait(state_t s);
    return (s == S_WAIT) || (s == S_VERIFY_WAIT);
  endfunction

endpackage

// File: rtl/carbon_init_seq_timer.sv
// Loadable down-counter; expired is high while the count is zero.
// Used as the per-step response timeout.
module carbon_init_seq_timer #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic         expired
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (en && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign expired = (cnt == '0);

endmodule

// File: rtl/carbon_init_seq.sv
// Boot-time CSR write sequencer: walks a step table, retries faults.
// Define CARBON_INIT_SEQ_READBACK_EN to verify each write by readback.
module carbon_init_seq
  import carbon_init_seq_pkg::*;
#(
  parameter int NUM_STEPS = 6,
  parameter int NUM_TGT   = 2,
  parameter logic [NUM_STEPS*3-1:0]  STEP_TGT   = '0,
  parameter logic [NUM_STEPS*32-1:0] STEP_ADDR  = '0,
  parameter logic [NUM_STEPS*32-1:0] STEP_WDATA = '0,
  parameter int MAX_RETRY      = 2,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  seq_enable,
  output logic [NUM_TGT-1:0]    cmd_start,
  output logic                  cmd_write,
  output logic [31:0]           cmd_addr,
  output logic [31:0]           cmd_wdata,
  output logic [3:0]            cmd_wstrb,
  output logic [1:0]            cmd_priv,
  input  logic [NUM_TGT-1:0]    tgt_busy,
  input  logic [NUM_TGT-1:0]    tgt_done,
  input  logic [NUM_TGT-1:0]    tgt_fault,
  input  logic [NUM_TGT*32-1:0] tgt_rdata,
  output logic                  halt_req,
  output logic                  run_pulse,
  output logic                  init_done,
  output logic                  init_error,
  output logic [5:0]            step_idx,
  output logic [5:0]            err_step
);

  localparam int IW = CARBON_INIT_SEQ_IDX_W;
  localparam logic [IW-1:0] LAST = IW'(NUM_STEPS - 1);
  localparam logic [RTY_W-1:0] RTY_MAX = RTY_W'(MAX_RETRY);
  localparam logic [TMR_W-1:0] TMO = TMR_W'(TIMEOUT_CYCLES);

  state_t state_q, state_d;
  logic [IW-1:0] step_q, step_d;
  logic [IW-1:0] err_q, err_d;
  logic [RTY_W-1:0] retry_q, retry_d;

  logic [2:0] tgt;
  logic [31:0] step_addr, step_wdata;
  logic [NUM_TGT-1:0] sel_oh;
  logic busy_sel, done_sel, fault_sel;
  logic expired, bad;

  always_comb begin
    tgt = STEP_TGT[int'(step_q)*3 +: 3];
    step_addr = STEP_ADDR[int'(step_q)*32 +: 32];
    step_wdata = STEP_WDATA[int'(step_q)*32 +: 32];
  end

  always_comb begin
    sel_oh = '0;
    for (int i = 0; i < NUM_TGT; i++) begin
      sel_oh[i] = (3'(i) == tgt);
    end
  end

  assign busy_sel  = |(tgt_busy & sel_oh);
  assign done_sel  = |(tgt_done & sel_oh);
  assign fault_sel = |(tgt_fault & sel_oh);

`ifdef CARBON_INIT_SEQ_READBACK_EN
  logic [31:0] rdata_sel;
  logic cmd_write_q;

  always_comb begin
    rdata_sel = '0;
    for (int i = 0; i < NUM_TGT; i++) begin
      if (sel_oh[i]) rdata_sel = tgt_rdata[i*32 +: 32];
    end
  end
`else
  logic unused_rdata;
  assign unused_rdata = ^tgt_rdata;
`endif

  carbon_init_seq_timer #(
    .W(TMR_W)
  ) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (is_issue(state_q)),
    .load_val (TMO),
    .en       (is_wait(state_q)),
    .expired  (expired)
  );

  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    retry_d = retry_q;
    err_d   = err_q;
    bad     = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (seq_enable && !busy_sel) state_d = S_ISSUE;
      end
      S_ISSUE: state_d = S_WAIT;
      S_WAIT: begin
        if (done_sel && !fault_sel) begin
`ifdef CARBON_INIT_SEQ_READBACK_EN
          state_d = S_VERIFY_ISSUE;
`else
          state_d = S_NEXT;
`endif
        end else if (done_sel || expired) begin
          bad = 1'b1;
        end
      end
`ifdef CARBON_INIT_SEQ_READBACK_EN
      S_VERIFY_ISSUE: state_d = S_VERIFY_WAIT;
      S_VERIFY_WAIT: begin
        if (done_sel) begin
          if (fault_sel || (rdata_sel != cmd_wdata)) begin
            bad = 1'b1;
          end else begin
            state_d = S_NEXT;
          end
        end else if (expired) begin
          bad = 1'b1;
        end
      end
`endif
      S_NEXT: begin
        retry_d = '0;
        if (step_q == LAST) begin
          state_d = S_RELEASE;
        end else begin
          step_d  = step_q + 1'b1;
          state_d = S_IDLE;
        end
      end
      S_RELEASE: state_d = S_DONE;
      S_DONE: ;
      S_ERROR: ;
      default: state_d = S_IDLE;
    endcase
    // A fault or timeout re-issues the write directly, without gating.
    if (bad) begin
      if (retry_q < RTY_MAX) begin
        retry_d = retry_q + 1'b1;
        state_d = S_ISSUE;
      end else begin
        state_d = S_ERROR;
        err_d   = step_q;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      step_q  <= '0;
      retry_q <= '0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      retry_q <= retry_d;
      err_q   <= err_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmd_addr  <= '0;
      cmd_wdata <= '0;
      cmd_wstrb <= '0;
      cmd_priv  <= '0;
    end else if (state_d == S_ISSUE) begin
      cmd_addr  <= step_addr;
      cmd_wdata <= step_wdata;
      cmd_wstrb <= CMD_WSTRB;
      cmd_priv  <= CMD_PRIV;
    end
  end

`ifdef CARBON_INIT_SEQ_READBACK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmd_write_q <= 1'b0;
    end else if (state_d == S_ISSUE) begin
      cmd_write_q <= 1'b1;
    end else if (state_d == S_VERIFY_ISSUE) begin
      cmd_write_q <= 1'b0;
    end
  end
  assign cmd_write = cmd_write_q;
`else
  assign cmd_write = 1'b1;
`endif

  assign cmd_start  = is_issue(state_q) ? sel_oh : '0;
  assign run_pulse  = (state_q == S_RELEASE);
  assign halt_req   = !((state_q == S_RELEASE) || (state_q == S_DONE));
  assign init_done  = (state_q == S_DONE);
  assign init_error = (state_q == S_ERROR);
  assign step_idx   = step_q;
  assign err_step   = err_q;

endmodule

// File: tb/tb_carbon_init_seq.sv
// Scoreboard bench for carbon_init_seq with a 3-cycle target model.
// Expected starts are queued; a monitor pops one per cmd_start.
module tb_carbon_init_seq;

  localparam int NS = 6;
  localparam int NT = 2;
`ifdef CARBON_INIT_SEQ_READBACK_EN
  localparam int RB = 1;
`else
  localparam int RB = 0;
`endif

  localparam logic [NS*3-1:0] P_TGT =
    {3'd0, 3'd1, 3'd0, 3'd1, 3'd1, 3'd0};
  localparam logic [NS*32-1:0] P_ADDR = {
    32'h0000_0114, 32'h0000_0110, 32'h0000_010C,
    32'h0000_0108, 32'h0000_0104, 32'h0000_0100};
  localparam logic [NS*32-1:0] P_WDATA = {
    32'hCAFE_0005, 32'hCAFE_0004, 32'hCAFE_0003,
    32'hCAFE_0002, 32'hCAFE_0001, 32'hCAFE_0000};

  logic [1:0]  e_oh [NS] = '{2'b01, 2'b10, 2'b10, 2'b01, 2'b10, 2'b01};
  logic [31:0] e_addr [NS] = '{32'h100, 32'h104, 32'h108,
                               32'h10C, 32'h110, 32'h114};
  logic [31:0] e_wd [NS] = '{32'hCAFE_0000, 32'hCAFE_0001,
                             32'hCAFE_0002, 32'hCAFE_0003,
                             32'hCAFE_0004, 32'hCAFE_0005};

  typedef struct packed {
    logic [1:0]  oh;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        wr;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic seq_enable = 1'b0;
  logic [NT-1:0] cmd_start;
  logic cmd_write;
  logic [31:0] cmd_addr, cmd_wdata;
  logic [3:0] cmd_wstrb;
  logic [1:0] cmd_priv;
  logic [NT-1:0] tgt_busy = '0;
  logic [NT-1:0] tgt_done = '0;
  logic [NT-1:0] tgt_fault = '0;
  logic [NT*32-1:0] tgt_rdata = '0;
  logic halt_req, run_pulse, init_done, init_error;
  logic [5:0] step_idx, err_step;

  int n_tests = 0;
  int n_fail = 0;
  int n_starts = 0;
  int n_run = 0;
  int cyc = 0;
  int last_t = 0;
  int gaps[$];
  exp_t q[$];

  int pend [NT];
  logic p_fault [NT];
  logic [31:0] p_rdata [NT];
  logic [31:0] mem [NT];
  logic silent = 1'b0;
  logic [31:0] fault_addr = 32'hFFFF_FFFF;
  int fault_left = 0;
  logic [31:0] bad_rd_addr = 32'hFFFF_FFFF;

  carbon_init_seq #(
    .NUM_STEPS(NS), .NUM_TGT(NT),
    .STEP_TGT(P_TGT), .STEP_ADDR(P_ADDR), .STEP_WDATA(P_WDATA),
    .MAX_RETRY(2), .TIMEOUT_CYCLES(10)
  ) dut (
    .clk(clk), .rst_n(rst_n), .seq_enable(seq_enable),
    .cmd_start(cmd_start), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .cmd_wstrb(cmd_wstrb), .cmd_priv(cmd_priv),
    .tgt_busy(tgt_busy), .tgt_done(tgt_done),
    .tgt_fault(tgt_fault), .tgt_rdata(tgt_rdata),
    .halt_req(halt_req), .run_pulse(run_pulse),
    .init_done(init_done), .init_error(init_error),
    .step_idx(step_idx), .err_step(err_step)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Target model: done (with optional fault) 3 cycles after a start.
  always @(negedge clk) begin
    cyc++;
    for (int i = 0; i < NT; i++) begin
      if (!rst_n) begin
        pend[i] = 0;
        tgt_done[i] = 1'b0;
        tgt_fault[i] = 1'b0;
      end else begin
        tgt_done[i] = 1'b0;
        tgt_fault[i] = 1'b0;
        if (pend[i] > 0) begin
          pend[i]--;
          if (pend[i] == 0) begin
            tgt_done[i] = 1'b1;
            tgt_fault[i] = p_fault[i];
            tgt_rdata[i*32 +: 32] = p_rdata[i];
          end
        end
        if (cmd_start[i] && !silent) begin
          pend[i] = 3;
          p_fault[i] = 1'b0;
          p_rdata[i] = 32'h0;
          if (cmd_write) begin
            mem[i] = cmd_wdata;
            if (cmd_addr == fault_addr && fault_left > 0) begin
              p_fault[i] = 1'b1;
              fault_left--;
            end
          end else begin
            p_rdata[i] = mem[i] ^
              ((cmd_addr == bad_rd_addr) ? 32'h1 : 32'h0);
          end
        end
      end
    end
  end

  // Monitor: every start pops and checks one expected command.
  always @(negedge clk) begin
    if (rst_n && run_pulse) n_run++;
    if (rst_n && (cmd_start != '0)) begin
      if (n_starts > 0) gaps.push_back(cyc - last_t);
      last_t = cyc;
      n_starts++;
      if (q.size() == 0) begin
        chk("unexpected_start", 64'(cmd_start), 64'h0);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("start_tgt", 64'(cmd_start), 64'(e.oh));
        chk("start_addr", 64'(cmd_addr), 64'(e.addr));
        chk("start_wdata", 64'(cmd_wdata), 64'(e.wdata));
        chk("start_write", 64'(cmd_write), 64'(e.wr));
        chk("start_wstrb", 64'(cmd_wstrb), 64'hF);
        chk("start_priv", 64'(cmd_priv), 64'h1);
      end
    end
  end

  task automatic push_cmd(input int i, input logic wr);
    exp_t e;
    e.oh = e_oh[i];
    e.addr = e_addr[i];
    e.wdata = e_wd[i];
    e.wr = wr;
    q.push_back(e);
  endtask

  task automatic push_step(input int i);
    push_cmd(i, 1'b1);
    if (RB != 0) push_cmd(i, 1'b0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    seq_enable = 1'b0;
    tgt_busy = '0;
    silent = 1'b0;
    fault_addr = 32'hFFFF_FFFF;
    fault_left = 0;
    bad_rd_addr = 32'hFFFF_FFFF;
    q.delete();
    gaps.delete();
    repeat (2) @(negedge clk);
    n_starts = 0;
    n_run = 0;
    rst_n = 1'b1;
  endtask

  task automatic wait_end(input int lim);
    int k;
    k = 0;
    while (!(init_done || init_error) && k < lim) begin
      @(negedge clk);
      k++;
    end
    chk("end_reached", 64'(k < lim), 64'h1);
  endtask

  initial begin
    for (int i = 0; i < NT; i++) mem[i] = '0;
    do_reset();
    @(negedge clk);
    chk("rst_halt", 64'(halt_req), 64'h1);
    chk("rst_done", 64'(init_done), 64'h0);
    chk("rst_err", 64'(init_error), 64'h0);
    chk("rst_run", 64'(run_pulse), 64'h0);
    chk("rst_step", 64'(step_idx), 64'h0);
    chk("rst_start", 64'(cmd_start), 64'h0);
    chk("rst_addr", 64'(cmd_addr), 64'h0);

    // Clean run of all six steps.
    for (int i = 0; i < NS; i++) push_step(i);
    seq_enable = 1'b1;
    wait_end(400);
    repeat (3) @(negedge clk);
    chk("clean_done", 64'(init_done), 64'h1);
    chk("clean_halt", 64'(halt_req), 64'h0);
    chk("clean_run", 64'(n_run), 64'h1);
    chk("clean_starts", 64'(n_starts), 64'(RB ? 12 : 6));
    chk("clean_q", 64'(q.size()), 64'h0);
    chk("clean_step", 64'(step_idx), 64'h5);
    seq_enable = 1'b0;
    repeat (5) @(negedge clk);
    chk("done_sticky", 64'(init_done), 64'h1);
    chk("done_halt", 64'(halt_req), 64'h0);

    // Step 2 faults once, then completes.
    do_reset();
    fault_addr = 32'h108;
    fault_left = 1;
    push_step(0);
    push_step(1);
    push_cmd(2, 1'b1);
    for (int i = 2; i < NS; i++) push_step(i);
    seq_enable = 1'b1;
    wait_end(400);
    repeat (2) @(negedge clk);
    chk("retry_done", 64'(init_done), 64'h1);
    chk("retry_starts", 64'(n_starts), 64'(RB ? 13 : 7));
    chk("retry_run", 64'(n_run), 64'h1);
    chk("retry_q", 64'(q.size()), 64'h0);

    // Step 3 faults three times: retries exhausted.
    do_reset();
    fault_addr = 32'h10C;
    fault_left = 3;
    for (int i = 0; i < 3; i++) push_step(i);
    repeat (3) push_cmd(3, 1'b1);
    seq_enable = 1'b1;
    wait_end(400);
    repeat (10) @(negedge clk);
    chk("err_flag", 64'(init_error), 64'h1);
    chk("err_step", 64'(err_step), 64'h3);
    chk("err_halt", 64'(halt_req), 64'h1);
    chk("err_run", 64'(n_run), 64'h0);
    chk("err_done", 64'(init_done), 64'h0);
    chk("err_starts", 64'(n_starts), 64'(RB ? 9 : 6));
    chk("err_q", 64'(q.size()), 64'h0);

    // Silent target: three timed-out issues 12 cycles apart.
    do_reset();
    chk("rst2_step", 64'(step_idx), 64'h0);
    chk("rst2_err", 64'(init_error), 64'h0);
    silent = 1'b1;
    repeat (3) push_cmd(0, 1'b1);
    seq_enable = 1'b1;
    wait_end(200);
    chk("tmo_err", 64'(init_error), 64'h1);
    chk("tmo_step", 64'(err_step), 64'h0);
    chk("tmo_starts", 64'(n_starts), 64'h3);
    chk("tmo_ngap", 64'(gaps.size()), 64'h2);
    if (gaps.size() == 2) begin
      chk("tmo_gap0", 64'(gaps[0]), 64'd12);
      chk("tmo_gap1", 64'(gaps[1]), 64'd12);
    end

    // Gating by seq_enable and target busy.
    do_reset();
    for (int i = 0; i < NS; i++) push_step(i);
    tgt_busy = 2'b01;
    repeat (20) @(negedge clk);
    chk("gate_off", 64'(n_starts), 64'h0);
    seq_enable = 1'b1;
    repeat (5) @(negedge clk);
    chk("gate_busy", 64'(n_starts), 64'h0);
    tgt_busy = 2'b00;
    for (int k = 0; k < 2 && n_starts == 0; k++) @(negedge clk);
    chk("gate_release", 64'(n_starts), 64'h1);
    wait_end(400);
    chk("gate_done", 64'(init_done), 64'h1);

`ifdef CARBON_INIT_SEQ_READBACK_EN
    // Readback on step 1 always off by one bit.
    do_reset();
    bad_rd_addr = 32'h104;
    push_step(0);
    repeat (3) push_step(1);
    seq_enable = 1'b1;
    wait_end(400);
    repeat (5) @(negedge clk);
    chk("rb_err", 64'(init_error), 64'h1);
    chk("rb_step", 64'(err_step), 64'h1);
    chk("rb_starts", 64'(n_starts), 64'd8);
    chk("rb_q", 64'(q.size()), 64'h0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
